// File: rtl/inst_queue_mp.sv
// inst_queue_mp: dual-lane instruction/PC queue between fetch and decode.
// Accepts up to two entries per cycle and presents the two oldest entries to ID.
// Pushes are all-or-nothing, pops are clamped to occupancy, and a dropped push
// raises a sticky overflow flag.
module inst_queue_mp #(
  parameter int DEPTH      = 16,
  parameter int DATA_W     = 32,
  parameter int PC_W       = 32,
  parameter int AFULL_FREE = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stop_pop,
  input  logic                       issue_i,
  input  logic                       issue_mode_i,
  input  logic [DATA_W-1:0]          inst1_i,
  input  logic [DATA_W-1:0]          inst2_i,
  input  logic [PC_W-1:0]            inst1_addr_i,
  input  logic [PC_W-1:0]            inst2_addr_i,
  input  logic                       inst1_valid_i,
  input  logic                       inst2_valid_i,
  output logic [DATA_W-1:0]          inst1_o,
  output logic [DATA_W-1:0]          inst2_o,
  output logic [PC_W-1:0]            inst1_addr_o,
  output logic [PC_W-1:0]            inst2_addr_o,
  output logic                       inst1_valid_o,
  output logic                       inst2_valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       buffer_full_o,
  output logic                       overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage is intentionally not reset; valids qualify its contents.
  logic [DATA_W-1:0] inst_mem [DEPTH];
  logic [PC_W-1:0]   addr_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic [1:0]        push_n;
  logic [1:0]        req_n;
  logic [1:0]        pop_n;
  logic              push_ok;
  logic              wr0_en;
  logic              wr1_en;
  logic [DATA_W-1:0] wr0_inst;
  logic [PC_W-1:0]   wr0_addr;
  logic [PTR_W-1:0]  tail_p1;
  logic [PTR_W-1:0]  head_p1;
  logic [CNT_W-1:0]  free_slots;

  assign tail_p1 = tail_q + PTR_W'(1);
  assign head_p1 = head_q + PTR_W'(1);

  // Push/pop sizing, space check and next-state pointer/count arithmetic.
  always_comb begin
    push_n   = 2'(inst1_valid_i) + 2'(inst2_valid_i);
    req_n    = 2'd0;
    if (issue_i && !stop_pop) begin
      req_n = issue_mode_i ? 2'd2 : 2'd1;
    end
    pop_n    = req_n;
    if (CNT_W'(req_n) > count_q) begin
      pop_n = count_q[1:0];
    end
    // Space check uses the pre-pop count: a same-cycle retirement is not credited.
    push_ok  = ({1'b0, count_q} + (CNT_W+1)'(push_n)) <= (CNT_W+1)'(DEPTH);
    // Lane compaction: the first valid lane always lands at tail.
    wr0_inst = inst1_valid_i ? inst1_i : inst2_i;
    wr0_addr = inst1_valid_i ? inst1_addr_i : inst2_addr_i;
    wr0_en   = !flush && push_ok && (push_n != 2'd0);
    wr1_en   = !flush && push_ok && (push_n == 2'd2);

    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_n);
      count_d = count_q - CNT_W'(pop_n);
      if (push_ok) begin
        tail_d  = tail_q + PTR_W'(push_n);
        count_d = count_d + CNT_W'(push_n);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // Control state: async clear on rst, otherwise load next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage writes: compacted lanes at tail and tail+1.
  always_ff @(posedge clk) begin
    if (wr0_en) begin
      inst_mem[tail_q] <= wr0_inst;
      addr_mem[tail_q] <= wr0_addr;
    end
    if (wr1_en) begin
      inst_mem[tail_p1] <= inst2_i;
      addr_mem[tail_p1] <= inst2_addr_i;
    end
  end

  assign free_slots = CNT_W'(DEPTH) - count_q;

  // Outputs are driven purely from registered state (plus the stop_pop mask).
  always_comb begin
    inst1_o       = inst_mem[head_q];
    inst2_o       = inst_mem[head_p1];
    inst1_addr_o  = addr_mem[head_q];
    inst2_addr_o  = addr_mem[head_p1];
    inst1_valid_o = !stop_pop && (count_q >= CNT_W'(1));
    inst2_valid_o = !stop_pop && (count_q >= CNT_W'(2));
    count_o       = count_q;
    buffer_full_o = free_slots < CNT_W'(AFULL_FREE);
    overflow_o    = overflow_q;
  end

endmodule

// File: tb/tb_inst_queue_mp.sv
// tb_inst_queue_mp: directed checks of inst_queue_mp with DEPTH=16, AFULL_FREE=6.
module tb_inst_queue_mp;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              stop_pop;
  logic              issue_i;
  logic              issue_mode_i;
  logic [DATA_W-1:0] inst1_i, inst2_i;
  logic [PC_W-1:0]   inst1_addr_i, inst2_addr_i;
  logic              inst1_valid_i, inst2_valid_i;
  logic [DATA_W-1:0] inst1_o, inst2_o;
  logic [PC_W-1:0]   inst1_addr_o, inst2_addr_o;
  logic              inst1_valid_o, inst2_valid_o;
  logic [CNT_W-1:0]  count_o;
  logic              buffer_full_o;
  logic              overflow_o;

  int n_cmp = 0;
  int n_err = 0;

  inst_queue_mp #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PC_W(PC_W), .AFULL_FREE(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stop_pop(stop_pop),
    .issue_i(issue_i), .issue_mode_i(issue_mode_i),
    .inst1_i(inst1_i), .inst2_i(inst2_i),
    .inst1_addr_i(inst1_addr_i), .inst2_addr_i(inst2_addr_i),
    .inst1_valid_i(inst1_valid_i), .inst2_valid_i(inst2_valid_i),
    .inst1_o(inst1_o), .inst2_o(inst2_o),
    .inst1_addr_o(inst1_addr_o), .inst2_addr_o(inst2_addr_o),
    .inst1_valid_o(inst1_valid_o), .inst2_valid_o(inst2_valid_o),
    .count_o(count_o), .buffer_full_o(buffer_full_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic v1, input logic [31:0] d1, input logic [31:0] a1,
                          input logic v2, input logic [31:0] d2, input logic [31:0] a2);
    inst1_valid_i = v1; inst1_i = d1; inst1_addr_i = a1;
    inst2_valid_i = v2; inst2_i = d2; inst2_addr_i = a2;
  endtask

  task automatic idle();
    set_push(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    issue_i = 1'b0; issue_mode_i = 1'b0; flush = 1'b0; stop_pop = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #12;
    // Reset state
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_v1", 64'(inst1_valid_o), 64'd0);
    chk("rst_v2", 64'(inst2_valid_o), 64'd0);
    chk("rst_full", 64'(buffer_full_o), 64'd0);
    chk("rst_ovf", 64'(overflow_o), 64'd0);
    rst = 1'b0;
    tick();

    // Three pair pushes, no issue
    set_push(1'b1, 32'hA0, 32'h100, 1'b1, 32'hA1, 32'h104);
    for (int i = 0; i < 3; i++) tick();
    idle();
    chk("pair_count", 64'(count_o), 64'd6);
    chk("pair_i1", 64'(inst1_o), 64'hA0);
    chk("pair_i2", 64'(inst2_o), 64'hA1);
    chk("pair_a1", 64'(inst1_addr_o), 64'h100);
    chk("pair_a2", 64'(inst2_addr_o), 64'h104);
    chk("pair_v1", 64'(inst1_valid_o), 64'd1);
    chk("pair_v2", 64'(inst2_valid_o), 64'd1);
    chk("pair_full", 64'(buffer_full_o), 64'd0);

    // One more pair to reach 8, then flush together with push-2 and issue
    set_push(1'b1, 32'hA2, 32'h108, 1'b1, 32'hA3, 32'h10C);
    tick();
    chk("pre_flush_count", 64'(count_o), 64'd8);
    flush = 1'b1; issue_i = 1'b1; issue_mode_i = 1'b1;
    tick();
    idle();
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_v1", 64'(inst1_valid_o), 64'd0);
    chk("flush_v2", 64'(inst2_valid_o), 64'd0);
    chk("flush_ovf", 64'(overflow_o), 64'd0);

    // inst2-only push into empty queue
    set_push(1'b0, 32'hDEAD, 32'h0, 1'b1, 32'hB0, 32'h200);
    tick();
    idle();
    chk("l2_i1", 64'(inst1_o), 64'hB0);
    chk("l2_a1", 64'(inst1_addr_o), 64'h200);
    chk("l2_v1", 64'(inst1_valid_o), 64'd1);
    chk("l2_v2", 64'(inst2_valid_o), 64'd0);
    chk("l2_count", 64'(count_o), 64'd1);
    // Dual request with one entry retires exactly one
    issue_i = 1'b1; issue_mode_i = 1'b1;
    tick();
    idle();
    chk("clamp_count", 64'(count_o), 64'd0);
    chk("clamp_v1", 64'(inst1_valid_o), 64'd0);
    set_push(1'b1, 32'hC0, 32'h300, 1'b1, 32'hC1, 32'h304);
    tick();
    idle();
    chk("clamp_head_i1", 64'(inst1_o), 64'hC0);
    chk("clamp_head_i2", 64'(inst2_o), 64'hC1);

    // Fill to 15 with threshold checks, then a rejected push-2
    flush = 1'b1;
    tick();
    idle();
    for (int k = 0; k < 5; k++) begin
      set_push(1'b1, 32'h10 + 2*k, 32'h400 + 8*k, 1'b1, 32'h11 + 2*k, 32'h404 + 8*k);
      tick();
    end
    idle();
    chk("thr10_full", 64'(buffer_full_o), 64'd0);
    set_push(1'b1, 32'h1A, 32'h428, 1'b0, 32'h0, 32'h0);
    tick();
    idle();
    chk("thr11_full", 64'(buffer_full_o), 64'd1);
    for (int k = 0; k < 2; k++) begin
      set_push(1'b1, 32'h1B + 2*k, 32'h42C + 8*k, 1'b1, 32'h1C + 2*k, 32'h430 + 8*k);
      tick();
    end
    idle();
    chk("fill15_count", 64'(count_o), 64'd15);
    chk("fill15_ovf", 64'(overflow_o), 64'd0);
    set_push(1'b1, 32'hEE, 32'hE00, 1'b1, 32'hEF, 32'hE04);
    tick();
    idle();
    chk("ovf_count", 64'(count_o), 64'd15);
    chk("ovf_flag", 64'(overflow_o), 64'd1);
    chk("ovf_head_i1", 64'(inst1_o), 64'h10);
    chk("ovf_head_a1", 64'(inst1_addr_o), 64'h400);
    flush = 1'b1;
    tick();
    idle();
    chk("ovf_sticky", 64'(overflow_o), 64'd1);
    chk("ovf_flush_count", 64'(count_o), 64'd0);

    // Full queue: single issue plus single-lane push
    for (int k = 0; k < 8; k++) begin
      set_push(1'b1, 32'hD0 + 2*k, 32'h500 + 8*k, 1'b1, 32'hD1 + 2*k, 32'h504 + 8*k);
      tick();
    end
    idle();
    chk("full16_count", 64'(count_o), 64'd16);
    chk("full16_full", 64'(buffer_full_o), 64'd1);
    set_push(1'b1, 32'hFF, 32'hF00, 1'b0, 32'h0, 32'h0);
    issue_i = 1'b1; issue_mode_i = 1'b0;
    tick();
    idle();
    chk("full_pop_count", 64'(count_o), 64'd15);
    chk("full_pop_i1", 64'(inst1_o), 64'hD1);
    chk("full_pop_i2", 64'(inst2_o), 64'hD2);

    // Wrap streaming: push-2 / dual issue for 40 cycles
    flush = 1'b1;
    tick();
    idle();
    for (int i = 0; i < 40; i++) begin
      set_push(1'b1, 32'(2*i), 32'(32'h1000 + 8*i), 1'b1, 32'(2*i+1), 32'(32'h1004 + 8*i));
      issue_i = 1'b1; issue_mode_i = 1'b1;
      tick();
      chk($sformatf("wrap_count_%0d", i), 64'(count_o), 64'd2);
      chk($sformatf("wrap_i1_%0d", i), 64'(inst1_o), 64'(2*i));
      chk($sformatf("wrap_i2_%0d", i), 64'(inst2_o), 64'(2*i+1));
    end
    idle();
    chk("wrap_a1", 64'(inst1_addr_o), 64'(32'h1000 + 8*39));

    // stop_pop with dual issue at count 4
    set_push(1'b1, 32'd80, 32'h2000, 1'b1, 32'd81, 32'h2004);
    tick();
    idle();
    chk("stop_pre_count", 64'(count_o), 64'd4);
    stop_pop = 1'b1; issue_i = 1'b1; issue_mode_i = 1'b1;
    #1;
    chk("stop_v1", 64'(inst1_valid_o), 64'd0);
    chk("stop_v2", 64'(inst2_valid_o), 64'd0);
    tick();
    chk("stop_count", 64'(count_o), 64'd4);
    idle();
    #1;
    chk("stop_rel_i1", 64'(inst1_o), 64'd78);
    chk("stop_rel_i2", 64'(inst2_o), 64'd79);
    chk("stop_rel_v1", 64'(inst1_valid_o), 64'd1);

    // Async reset pulse between clock edges
    #1;
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_ovf", 64'(overflow_o), 64'd0);
    chk("arst_v1", 64'(inst1_valid_o), 64'd0);
    rst = 1'b0;
    tick();
    chk("arst_hold_count", 64'(count_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inst_queue_mp.md
Name: inst_queue_mp

Overview:
- Parametrised successor to the front-end dual-issue instruction buffer, placed between fetch (IF) and decode (ID).
- Accepts 0/1/2 instruction+PC pairs per cycle from fetch and presents the two oldest entries to ID in program order.
- Retires 0/1/2 entries per cycle according to the ID issue mode.
- Over its predecessor it adds: exact occupancy tracking, all-or-nothing overflow protection, pops clamped to occupancy, a programmable almost-full threshold and a sticky error flag.

Parameters:
- DEPTH, 16, number of entries; power of two, minimum 4.
- DATA_W, 32, instruction word width.
- PC_W, 32, instruction address width.
- AFULL_FREE, 6, buffer_full_o asserts when free slots < AFULL_FREE; covers fetch requests already in flight; legal range 2..DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous queue clear (branch mispredict or exception).
- stop_pop  in  1  ID stall: masks output valids and blocks retirement.
- issue_i  in  1  ID consumed the presented entries this cycle.
- issue_mode_i  in  1  0 = single issue (retire 1), 1 = dual issue (retire 2).
- inst1_i, inst2_i  in  DATA_W  fetched instructions; inst1 is older.
- inst1_addr_i, inst2_addr_i  in  PC_W  PCs of the fetched instructions.
- inst1_valid_i, inst2_valid_i  in  1  per-lane push valid.
- inst1_o, inst2_o  out  DATA_W  entries at head and head+1.
- inst1_addr_o, inst2_addr_o  out  PC_W  PCs of those entries.
- inst1_valid_o, inst2_valid_o  out  1  head / head+1 entry present.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- buffer_full_o  out  1  almost-full backpressure to fetch.
- overflow_o  out  1  sticky error: a push was dropped.

Behaviour:
- Reset (async, rst=1):
  - head, tail and count clear to 0; overflow_o = 0.
  - inst*_valid_o = 0; buffer_full_o = 0 (AFULL_FREE <= DEPTH).
  - Storage arrays are not reset.
- Output timing:
  - All outputs are combinational from registered state; push-to-visible latency is 1 cycle. No bypass of a same-cycle push to the outputs.
  - inst1_valid_o = !stop_pop && count>=1; inst2_valid_o = !stop_pop && count>=2.
  - Data and PC outputs are don't-care when the matching valid is low.
- Push:
  - push_n = inst1_valid_i + inst2_valid_i.
  - Lanes are compacted: the first valid lane is written at tail, the second at tail+1. inst2-only writes inst2 at tail.
  - All-or-nothing: the push is accepted only if count + push_n <= DEPTH. Space is checked against the registered count; the same cycle's pop is not credited.
  - A rejected push writes nothing, leaves tail unchanged and sets overflow_o on the next edge. overflow_o holds until rst; flush does not clear it.
- Pop:
  - req_n = issue_i ? (issue_mode_i ? 2 : 1) : 0, forced to 0 when stop_pop = 1.
  - pop_n = min(req_n, count). A dual request with count = 1 retires exactly 1 and head advances by 1.
- Update:
  - head += pop_n; tail += accepted push_n; both wrap modulo DEPTH via natural PTR_W overflow.
  - count_next = count - pop_n + accepted push_n; count never leaves 0..DEPTH.
- Simultaneous push and pop is legal, including at count = DEPTH: the pop proceeds, the push is rejected (space check uses pre-pop count).
- Flush:
  - Synchronous. Priority over push and pop in the same cycle.
  - Next state: head = tail = count = 0. Same-cycle inputs are discarded and do not set overflow_o.
- buffer_full_o = (DEPTH - count) < AFULL_FREE, from registered count.
- Reset asserted mid-operation: immediate clear regardless of clk; pending push or pop is lost.

Test Plan:
- After reset, push pairs (0xA0,PC 0x100)/(0xA1,0x104) for 3 cycles, no issue -> count_o 6; inst1_o=0xA0, inst2_o=0xA1; both valids 1; buffer_full_o 0 (DEPTH=16, free 10).
- inst2-only push of 0xB0 into an empty queue -> next cycle inst1_o=0xB0, inst1_valid_o=1, inst2_valid_o=0, count_o=1. Then dual issue -> count_o=0, head advanced by 1 only.
- Fill to 15, push 2 with no pop -> nothing written, count_o stays 15, overflow_o=1 and persists after a later flush. Separately at 16 entries, single issue plus 1-lane push in the same cycle -> count_o=15, push rejected.
- Wrap: 40 cycles of push-2/dual-issue streaming with incrementing data -> outputs emerge strictly in push order across pointer wrap, count_o constant at 2.
- stop_pop=1 with issue_i=1, mode dual, count 4 -> valids 0, count_o stays 4; deassert -> head entries unchanged.
- Flush asserted together with a push-2 and an issue at count 8 -> next cycle count_o=0, valids 0, overflow_o unchanged. Async rst pulse between edges -> count_o=0 immediately.
